ntt_bfu: RTL

NTT_BFU -- requirements
Module: ntt_bfu

---
 rtl/ntt_bfu_pkg.sv | 28 ++
 rtl/ntt_bfu_barrett_reduce.sv | 26 ++
 rtl/ntt_bfu.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ntt_bfu_pkg.sv
// Shared constants, pipeline side-band type and the modular helper for the NTT butterfly unit.
// Q = 3329, Barrett constant M = floor(2^24 / Q).
package ntt_bfu_pkg;

    localparam int DATAWIDTH = 12;
    localparam int ADDRWIDTH = 8;
    localparam int SUMWIDTH  = DATAWIDTH + 1;
    localparam int PRODWIDTH = 2 * DATAWIDTH;
    localparam int BARRETT_W = PRODWIDTH + 13;
    localparam int LATENCY   = 4;

    localparam int unsigned Q_MOD         = 3329;
    localparam int unsigned BARRETT_M     = 5039;
    localparam int unsigned BARRETT_SHIFT = 24;

    typedef struct packed {
        logic                 valid;
        logic                 flag;
        logic [ADDRWIDTH-1:0] addr0;
        logic [ADDRWIDTH-1:0] addr1;
    } ctrl_t;

    // Valid only for x < 2Q: a single subtraction then lands in [0, Q).
    function automatic logic [DATAWIDTH-1:0] cond_sub_q(input logic [SUMWIDTH-1:0] x);
        return DATAWIDTH'((x >= SUMWIDTH'(Q_MOD)) ? x - SUMWIDTH'(Q_MOD) : x);
    endfunction

endpackage

// File: rtl/ntt_bfu_barrett_reduce.sv
// Combinational Barrett reduction of a 24-bit product modulo Q.
// The caller registers the result.
module barrett_reduce
    import ntt_bfu_pkg::*;
(
    input  logic [PRODWIDTH-1:0] p_i,
    output logic [DATAWIDTH-1:0] r_o
);

    logic [12:0]          t;
    logic [PRODWIDTH+1:0] diff;
    logic [13:0]          r0;
    logic [13:0]          r1;
    logic [13:0]          r2;

    // The quotient estimate undershoots by at most 2, so r0 < 3Q and fits 14 bits.
    always_comb begin
        t    = 13'((BARRETT_W'(p_i) * BARRETT_W'(BARRETT_M)) >> BARRETT_SHIFT);
        diff = (PRODWIDTH+2)'(p_i) - (PRODWIDTH+2)'(t) * (PRODWIDTH+2)'(Q_MOD);
        r0   = 14'(diff);
        r1   = (r0 >= 14'(Q_MOD)) ? r0 - 14'(Q_MOD) : r0;
        r2   = (r1 >= 14'(Q_MOD)) ? r1 - 14'(Q_MOD) : r1;
        r_o  = DATAWIDTH'(r2);
    end

endmodule

// File: rtl/ntt_bfu.sv
// Four-stage Cooley-Tukey butterfly mod 3329: a' = a + w*b, b' = a - w*b.
// Side-band (valid, stage flag, write addresses) shifts alongside the data; no stalls.
module ntt_bfu
    import ntt_bfu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bfu_en,
    input  logic                 stage_flag,
    input  logic [DATAWIDTH-1:0] a_in,
    input  logic [DATAWIDTH-1:0] b_in,
    input  logic [DATAWIDTH-1:0] w_in,
    input  logic [ADDRWIDTH-1:0] w_addr_0_in,
    input  logic [ADDRWIDTH-1:0] w_addr_1_in,
    output logic [DATAWIDTH-1:0] a_out,
    output logic [DATAWIDTH-1:0] b_out,
    output logic [ADDRWIDTH-1:0] w_addr_0_out,
    output logic [ADDRWIDTH-1:0] w_addr_1_out,
    output logic                 out_valid,
    output logic                 stage_done,
    output logic                 busy
);

    ctrl_t ctrl_in [LATENCY];
    ctrl_t ctrl_q  [LATENCY];

    logic [DATAWIDTH-1:0] a1_d, b1_d, w1_d;
    logic [DATAWIDTH-1:0] a1_q, b1_q, w1_q;
    logic [PRODWIDTH-1:0] p2_d, p2_q;
    logic [DATAWIDTH-1:0] a2_q;
    logic [DATAWIDTH-1:0] r3_d, r3_q, a3_q;
    logic [SUMWIDTH-1:0]  sum, diff;
    logic [DATAWIDTH-1:0] a4_d, b4_d, a4_q, b4_q;

    barrett_reduce u_barrett (
        .p_i (p2_q),
        .r_o (r3_d)
    );

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        ctrl_in[0] = '{valid: bfu_en, flag: bfu_en & stage_flag,
                       addr0: w_addr_0_in, addr1: w_addr_1_in};
        for (int i = 1; i < LATENCY; i++) begin
            ctrl_in[i] = ctrl_q[i-1];
        end

        a1_d = cond_sub_q(SUMWIDTH'(a_in));
        b1_d = cond_sub_q(SUMWIDTH'(b_in));
        w1_d = cond_sub_q(SUMWIDTH'(w_in));

        p2_d = PRODWIDTH'(w1_q) * PRODWIDTH'(b1_q);

        // Both operands are below Q, so the difference fits 13-bit two's complement.
        sum  = SUMWIDTH'(a3_q) + SUMWIDTH'(r3_q);
        diff = SUMWIDTH'(a3_q) - SUMWIDTH'(r3_q);
        a4_d = cond_sub_q(sum);
        b4_d = diff[SUMWIDTH-1] ? DATAWIDTH'(diff + SUMWIDTH'(Q_MOD)) : DATAWIDTH'(diff);
    end

    // NOTE: sequential state uses non-blocking assignments so every stage reads pre-edge values.
    // NOTE: data registers are reset as well, which keeps every output at 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                ctrl_q[i] <= '0;
            end
            a1_q <= '0;
            b1_q <= '0;
            w1_q <= '0;
            a2_q <= '0;
            p2_q <= '0;
            a3_q <= '0;
            r3_q <= '0;
            a4_q <= '0;
            b4_q <= '0;
        end else begin
            // Valid and flag always shift; payload only loads behind a valid so bubbles hold it.
            for (int i = 0; i < LATENCY; i++) begin
                ctrl_q[i].valid <= ctrl_in[i].valid;
                ctrl_q[i].flag  <= ctrl_in[i].flag;
                if (ctrl_in[i].valid) begin
                    ctrl_q[i].addr0 <= ctrl_in[i].addr0;
                    ctrl_q[i].addr1 <= ctrl_in[i].addr1;
                end
            end
            if (ctrl_in[0].valid) begin
                a1_q <= a1_d;
                b1_q <= b1_d;
                w1_q <= w1_d;
            end
            if (ctrl_in[1].valid) begin
                a2_q <= a1_q;
                p2_q <= p2_d;
            end
            if (ctrl_in[2].valid) begin
                a3_q <= a2_q;
                r3_q <= r3_d;
            end
            if (ctrl_in[3].valid) begin
                a4_q <= a4_d;
                b4_q <= b4_d;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | ctrl_q[i].valid;
        end
    end

    assign a_out        = a4_q;
    assign b_out        = b4_q;
    assign w_addr_0_out = ctrl_q[LATENCY-1].addr0;
    assign w_addr_1_out = ctrl_q[LATENCY-1].addr1;
    assign out_valid    = ctrl_q[LATENCY-1].valid;
    assign stage_done   = ctrl_q[LATENCY-1].valid & ctrl_q[LATENCY-1].flag;

endmodule
